activation_table_loader: RTL and testbench

- Writer side of the activation lookup tables: streams (tag, sigmoid, tanh) entries in over a valid/ready handshake and writes them into the tag memory and packed activation memory that the activation tag-search block reads.
- Enforces the search precondition, strictly increasing signed tags, while loading.
- Reports done, error and entry count to the NPU control sequencer.

---
 rtl/activation_table_loader.sv | 135 +++++++++++++
 tb/tb_activation_table_loader.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/activation_table_loader.sv
// Loads (tag, sigmoid, tanh) entries into the activation tag/value memories.
// Define ACT_LOADER_ORDER_CHECK_EN to enforce strictly increasing signed tags.
module activation_table_loader #(
  parameter int DATAWIDTH = 16,
  parameter int INWIDTH   = 10
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATAWIDTH-1:0]   in_tag,
  input  logic [DATAWIDTH-1:0]   in_sig,
  input  logic [DATAWIDTH-1:0]   in_tanh,
  output logic                   tag_we,
  output logic [INWIDTH-1:0]     tag_addr,
  output logic [DATAWIDTH-1:0]   tag_wdata,
  output logic                   act_we,
  output logic [INWIDTH-1:0]     act_addr,
  output logic [2*DATAWIDTH-1:0] act_wdata,
  output logic                   busy,
  output logic                   done,
  output logic                   order_error,
  output logic [INWIDTH:0]       entry_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [INWIDTH:0] LAST_IDX = {1'b0, {INWIDTH{1'b1}}};

  state_t                 state_reg, state_next;
  logic [INWIDTH:0]       count_reg;
  logic                   we_reg;
  logic [INWIDTH-1:0]     addr_reg;
  logic [DATAWIDTH-1:0]   tag_data_reg;
  logic [2*DATAWIDTH-1:0] act_data_reg;

  logic accept;
  logic order_bad;
  logic write_ok;

  assign accept   = in_valid && (state_reg == S_LOAD);
  // A start in LOAD wins over a simultaneous accept, so that entry is dropped.
  assign write_ok = accept && !start && !order_bad;

`ifdef ACT_LOADER_ORDER_CHECK_EN
  logic [DATAWIDTH-1:0] prev_tag_reg;

  assign order_bad = (count_reg != '0) && ($signed(in_tag) <= $signed(prev_tag_reg));

  always_ff @(posedge clock) begin
    if (!reset) begin
      prev_tag_reg <= '0;
    end else if (write_ok) begin
      prev_tag_reg <= in_tag;
    end
  end
`else
  assign order_bad = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        if (start) begin
          state_next = S_LOAD;
        end else if (accept && order_bad) begin
          state_next = S_ERROR;
        end else if (write_ok && (count_reg == LAST_IDX)) begin
          state_next = S_DONE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // The count doubles as the write pointer; it advances on the accept edge so the
  // registered write and the updated count appear together in the next cycle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      count_reg    <= '0;
      we_reg       <= 1'b0;
      addr_reg     <= '0;
      tag_data_reg <= '0;
      act_data_reg <= '0;
    end else begin
      we_reg <= write_ok;
      if (write_ok) begin
        addr_reg     <= count_reg[INWIDTH-1:0];
        tag_data_reg <= in_tag;
        act_data_reg <= {in_sig, in_tanh};
        count_reg    <= count_reg + 1'b1;
      end
      if (start) begin
        count_reg <= '0;
      end
    end
  end

  assign in_ready    = (state_reg == S_LOAD);
  assign busy        = (state_reg == S_LOAD);
  assign done        = (state_reg == S_DONE);
`ifdef ACT_LOADER_ORDER_CHECK_EN
  assign order_error = (state_reg == S_ERROR);
`else
  assign order_error = 1'b0;
`endif
  assign tag_we      = we_reg;
  assign act_we      = we_reg;
  assign tag_addr    = addr_reg;
  assign act_addr    = addr_reg;
  assign tag_wdata   = tag_data_reg;
  assign act_wdata   = act_data_reg;
  assign entry_count = count_reg;

endmodule

// File: tb/tb_activation_table_loader.sv
// Directed/randomized bench for activation_table_loader with a queue-based table model.
module tb_activation_table_loader;
  localparam int DW    = 16;
  localparam int IW    = 3;
  localparam int DEPTH = 8;
`ifdef ACT_LOADER_ORDER_CHECK_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset, start, in_valid, in_ready;
  logic [DW-1:0] in_tag, in_sig, in_tanh;
  logic          tag_we, act_we;
  logic [IW-1:0] tag_addr, act_addr;
  logic [DW-1:0] tag_wdata;
  logic [2*DW-1:0] act_wdata;
  logic          busy, done, order_error;
  logic [IW:0]   entry_count;

  always #5 clock = ~clock;

  activation_table_loader #(.DATAWIDTH(DW), .INWIDTH(IW)) dut (
    .clock(clock), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_tag(in_tag), .in_sig(in_sig), .in_tanh(in_tanh),
    .tag_we(tag_we), .tag_addr(tag_addr), .tag_wdata(tag_wdata),
    .act_we(act_we), .act_addr(act_addr), .act_wdata(act_wdata),
    .busy(busy), .done(done), .order_error(order_error), .entry_count(entry_count)
  );

  typedef struct {
    int          addr;
    logic [15:0] tag;
    logic [31:0] act;
    int          cyc;
  } wr_t;

  wr_t obs_q[$];
  wr_t exp_q[$];
  logic [15:0] img_tag[DEPTH];
  logic [31:0] img_act[DEPTH];
  logic [15:0] ref_tag[DEPTH];
  logic [31:0] ref_act[DEPTH];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Model of the loader's contract: entries in, table image and status out.
  bit                 m_load = 1'b0;
  bit                 m_err  = 1'b0;
  int                 m_n    = 0;
  logic signed [15:0] m_prev = '0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", nm, obs, exp);
    end
  endtask

  // Records every memory write the DUT issues, as the tag/activation RAMs would.
  always @(negedge clock) begin
    if (tag_we === 1'b1 || act_we === 1'b1) begin
      chk("we_addr_pair", {act_we, act_addr}, {tag_we, tag_addr});
      obs_q.push_back(wr_t'{int'(tag_addr), tag_wdata, act_wdata, cyc});
      img_tag[tag_addr] <= tag_wdata;
      img_act[tag_addr] <= act_wdata;
    end
  end

  task automatic chk_zero(input string nm);
    chk({nm, "_ctl"}, {in_ready, tag_we, act_we, busy, done, order_error, entry_count}, 64'd0);
    chk({nm, "_data"}, {tag_addr, act_addr, tag_wdata, act_wdata}, 64'd0);
  endtask

  task automatic chk_status(input string nm);
    bit e_busy, e_done;
    e_busy = m_load && !m_err && (m_n < DEPTH);
    e_done = m_load && (m_n == DEPTH);
    chk({nm, "_busy"}, busy, e_busy);
    chk({nm, "_ready"}, in_ready, e_busy);
    chk({nm, "_done"}, done, e_done);
    chk({nm, "_err"}, order_error, m_err);
    chk({nm, "_count"}, entry_count, m_n);
  endtask

  task automatic offer(input logic [15:0] t, input logic [15:0] s, input logic [15:0] h);
    bit exp_rdy, ok;
    in_valid = 1'b1;
    in_tag   = t;
    in_sig   = s;
    in_tanh  = h;
    exp_rdy  = m_load && !m_err && (m_n < DEPTH);
    chk("offer_ready", in_ready, exp_rdy);
    if (exp_rdy) begin
      ok = !CK_EN || (m_n == 0) || ($signed(t) > m_prev);
      if (ok) begin
        exp_q.push_back(wr_t'{m_n, t, {s, h}, cyc + 1});
        ref_tag[m_n] = t;
        ref_act[m_n] = {s, h};
        m_prev = t;
        m_n++;
      end else begin
        m_err = 1'b1;
      end
    end
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  task automatic begin_load(input bit with_valid, input logic [15:0] t);
    obs_q.delete();
    exp_q.delete();
    in_valid = with_valid;
    in_tag   = t;
    in_sig   = 16'h5A5A;
    in_tanh  = 16'hA5A5;
    start    = 1'b1;
    @(negedge clock);
    start    = 1'b0;
    in_valid = 1'b0;
    m_load   = 1'b1;
    m_err    = 1'b0;
    m_n      = 0;
    chk_status("after_start");
  endtask

  task automatic verify(input string nm);
    int n;
    idle(2);
    #1;
    chk({nm, "_nwrites"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_w%0d_addr", nm, i), obs_q[i].addr, exp_q[i].addr);
      chk($sformatf("%s_w%0d_tag", nm, i), obs_q[i].tag, exp_q[i].tag);
      chk($sformatf("%s_w%0d_act", nm, i), obs_q[i].act, exp_q[i].act);
      chk($sformatf("%s_w%0d_cyc", nm, i), obs_q[i].cyc, exp_q[i].cyc);
    end
    chk_status(nm);
  endtask

  task automatic chk_image(input string nm);
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("%s_img%0d", nm, i), {img_tag[i], img_act[i]}, {ref_tag[i], ref_act[i]});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int tv;
    for (int i = 0; i < DEPTH; i++) begin
      img_tag[i] = '0; img_act[i] = '0; ref_tag[i] = '0; ref_act[i] = '0;
    end
    reset = 1'b0; start = 1'b0; in_valid = 1'b0;
    in_tag = '0; in_sig = '0; in_tanh = '0;
    repeat (2) @(negedge clock);
    chk_zero("reset");
    reset = 1'b1;
    idle(1);

    // Back-to-back full table with the fixed stream.
    begin_load(1'b0, 16'h0);
    for (int i = 0; i < DEPTH; i++) begin
      offer(16'(-4 + i), 16'((i + 1) << 8), 16'((i + 1) << 12));
    end
    chk("b2b_done_next", {done, busy, in_ready, entry_count}, {1'b1, 1'b0, 1'b0, 4'd8});
    chk("b2b_last_write", {tag_we, tag_addr}, {1'b1, 3'd7});
    verify("b2b");
    chk("b2b_act0", img_act[0], 32'h0100_1000);
    chk_image("b2b");

    // Same stream with in_valid toggling every other cycle.
    begin_load(1'b0, 16'h0);
    for (int i = 0; i < DEPTH; i++) begin
      offer(16'(-4 + i), 16'((i + 1) << 8), 16'((i + 1) << 12));
      idle(1);
    end
    verify("toggle");
    chk_image("toggle");

    // Random increasing tags with random gaps.
    begin_load(1'b0, 16'h0);
    tv = -int'($urandom_range(1000));
    for (int i = 0; i < DEPTH; i++) begin
      tv += int'($urandom_range(50, 1));
      offer(16'(tv), 16'($urandom), 16'($urandom));
      idle(int'($urandom_range(1, 0)));
    end
    verify("rand");
    chk_image("rand");

    // Duplicate tag: error with the check enabled, plain write otherwise.
    begin_load(1'b0, 16'h0);
    offer(16'd5, 16'($urandom), 16'($urandom));
    offer(16'd7, 16'($urandom), 16'($urandom));
    offer(16'd7, 16'($urandom), 16'($urandom));
    offer(16'd8, 16'($urandom), 16'($urandom));
    verify("dup");
    begin_load(1'b0, 16'h0);
    offer(16'd1, 16'($urandom), 16'($urandom));
    verify("after_dup");

    // Restart after 4 accepts; the accept coinciding with start is dropped.
    begin_load(1'b0, 16'h0);
    for (int i = 0; i < 4; i++) offer(16'(10 * (i + 1)), 16'($urandom), 16'($urandom));
    verify("pre_restart");
    begin_load(1'b1, 16'd50);
    offer(-16'sd100, 16'($urandom), 16'($urandom));
    offer(-16'sd99, 16'($urandom), 16'($urandom));
    verify("restart");

    // Reset in the middle of a load.
    begin_load(1'b0, 16'h0);
    for (int i = 0; i < 3; i++) offer(16'(i), 16'($urandom), 16'($urandom));
    reset = 1'b0;
    @(negedge clock);
    chk_zero("midreset");
    reset  = 1'b1;
    m_load = 1'b0;
    m_err  = 1'b0;
    m_n    = 0;
    for (int i = 0; i < 4; i++) offer(16'($urandom), 16'($urandom), 16'($urandom));
    verify("idle_ignore");

    // Decreasing tags.
    begin_load(1'b0, 16'h0);
    offer(16'd9, 16'($urandom), 16'($urandom));
    offer(16'd2, 16'($urandom), 16'($urandom));
    verify("decr");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
